// File: rtl/ccff_loader.sv
// ---------------------------------------------------------------------------
// ccff_loader
//
// Purpose:
//   Streams a word-oriented configuration bitstream into a serial chain of
//   configuration flip-flops (CCFF). Each accepted word is emitted MSB first,
//   one bit per prog_clk cycle. Exactly CHAIN_LEN bits are shifted. Any
//   trailing LSBs of the final word that do not fit in the chain are dropped.
//   A new word can be accepted in the same cycle that the last bit of the
//   previous word shifts. Continuous input therefore streams with no bubble.
//
// Optional feature (macro CCFF_READBACK_EN):
//   When defined, the loader computes a CRC-16 over the loaded bits. The
//   CRC uses polynomial 0x1021, initial value 0xFFFF and MSB-first order.
//   After the load it recirculates the chain once through ccff_tail ->
//   ccff_head. The chain contents are preserved during this pass. The
//   loader computes a second CRC over the tail stream and flags error when
//   the two CRCs differ.
//   When undefined, no CRC or verify logic is built, error is tied to 0, and
//   ccff_tail is ignored.
//
// Parameters:
//   CHAIN_LEN  number of flip-flops in the target chain (>= 1)
//   WORD_W     bitstream word width (>= 1)
//
// Ports:
//   prog_clk       in   programming clock, all state on rising edge
//   pReset         in   asynchronous active-low reset
//   start          in   single-cycle request to begin a load (IDLE/DONE only)
//   bs_data        in   bitstream word, MSB shifted first
//   bs_valid       in   bs_data valid
//   bs_ready       out  word accepted when bs_valid && bs_ready
//   ccff_head      out  serial bit into the chain head
//   ccff_shift_en  out  chain advances on each prog_clk edge where high
//   ccff_tail      in   serial bit from the chain tail (used only in verify)
//   busy           out  high while loading or verifying
//   done           out  high in DONE until the next start
//   error          out  readback CRC mismatch (constant 0 without the macro)
// ---------------------------------------------------------------------------
module ccff_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Counter widths. CW holds 0..CHAIN_LEN and SW holds 0..WORD_W.
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int SW = $clog2(WORD_W + 1);
  // Common width used to compare the chain counter against WORD_W safely.
  localparam int XW = (CW > SW) ? CW : SW;

`ifdef CCFF_READBACK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t              state_reg;
  // Word shift register. Its MSB is the bit currently presented on the head.
  logic [WORD_W-1:0]   sr_reg;
  // Bits still to be emitted from sr_reg, including the one presented now.
  logic [SW-1:0]       sr_cnt_reg;
  // Chain bits not yet committed to the shift register. This counter is the
  // bit counter of the load. It counts down from CHAIN_LEN.
  logic [CW-1:0]       left_reg;
  // The head is kept in its own register so that it holds its value across
  // stalls. Without it, the shifted-out register would expose a stale 0.
  logic                head_reg;

  // -------------------------------------------------------------------------
  // Datapath decode (functions of registered state only)
  // -------------------------------------------------------------------------
  logic                load_shift;     // a chain bit shifts at this edge
  logic                last_in_word;   // the presented bit is the word's last
  logic                last_load_bit;  // the CHAIN_LEN-th bit shifts now
  logic                ready;
  logic                accept;
  logic [XW-1:0]       left_x;
  logic [SW-1:0]       take;           // bits of the next word that fit
  logic [WORD_W-1:0]   sr_shifted;

  always_comb begin
    load_shift    = (state_reg == LOAD) && (sr_cnt_reg != '0);
    last_in_word  = (sr_cnt_reg == SW'(1));
    last_load_bit = load_shift && last_in_word && (left_reg == '0);
    // Accept a word when the register is empty, or when its last bit leaves
    // at this very edge. This gives back-to-back streaming without a gap.
    ready         = (state_reg == LOAD) && (left_reg != '0) &&
                    ((sr_cnt_reg == '0) || last_in_word);
    accept        = ready && bs_valid;
    left_x        = XW'(left_reg);
    // The final word may contain more bits than the chain still needs. The
    // excess LSBs are never counted, so they are never shifted out.
    take          = (left_x >= XW'(WORD_W)) ? SW'(WORD_W) : SW'(left_x);
    sr_shifted    = sr_reg << 1;
  end

`ifdef CCFF_READBACK_EN
  // -------------------------------------------------------------------------
  // CRC-16 (poly 0x1021, MSB first) and readback bookkeeping
  // -------------------------------------------------------------------------
  logic [15:0]   crc_load_reg;   // CRC over the bits pushed into the chain
  logic [15:0]   crc_rb_reg;     // CRC over the bits read back at the tail
  logic [CW-1:0] vcnt_reg;       // recirculation cycles remaining
  logic          error_reg;
  logic [15:0]   crc_load_next;
  logic [15:0]   crc_rb_next;

  function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                           input logic        bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always_comb begin
    crc_load_next = crc_step(crc_load_reg, head_reg);
    crc_rb_next   = crc_step(crc_rb_reg, ccff_tail);
  end
`else
  // The tail is only observed during readback, which is not built here.
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  // -------------------------------------------------------------------------
  // Control FSM and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_reg    <= IDLE;
      sr_reg       <= '0;
      sr_cnt_reg   <= '0;
      left_reg     <= '0;
      head_reg     <= 1'b0;
`ifdef CCFF_READBACK_EN
      crc_load_reg <= 16'hFFFF;
      crc_rb_reg   <= 16'hFFFF;
      vcnt_reg     <= '0;
      error_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= LOAD;
            sr_reg       <= '0;
            sr_cnt_reg   <= '0;
            left_reg     <= CW'(CHAIN_LEN);
`ifdef CCFF_READBACK_EN
            crc_load_reg <= 16'hFFFF;
            error_reg    <= 1'b0;
`endif
          end
        end

        LOAD: begin
          if (accept) begin
            // A new word overrides the final shift of the previous word.
            // The previous word's last bit still leaves at this edge.
            sr_reg     <= bs_data;
            sr_cnt_reg <= take;
            left_reg   <= left_reg - CW'(take);
            head_reg   <= bs_data[WORD_W-1];
          end else if (load_shift) begin
            sr_reg     <= sr_shifted;
            sr_cnt_reg <= sr_cnt_reg - SW'(1);
            // After the last bit of a word, the head keeps that bit until
            // the next word arrives.
            if (!last_in_word) begin
              head_reg <= sr_shifted[WORD_W-1];
            end
          end
`ifdef CCFF_READBACK_EN
          if (load_shift) begin
            crc_load_reg <= crc_load_next;
          end
          if (last_load_bit) begin
            state_reg  <= VERIFY;
            vcnt_reg   <= CW'(CHAIN_LEN);
            crc_rb_reg <= 16'hFFFF;
          end
`else
          if (last_load_bit) begin
            state_reg <= DONE;
          end
`endif
        end

`ifdef CCFF_READBACK_EN
        VERIFY: begin
          // Each cycle the chain rotates by one bit: the tail is fed back to
          // the head. After CHAIN_LEN cycles every flip-flop holds its
          // original value again.
          crc_rb_reg <= crc_rb_next;
          vcnt_reg   <= vcnt_reg - CW'(1);
          if (vcnt_reg == CW'(1)) begin
            error_reg <= (crc_rb_next != crc_load_reg);
            state_reg <= DONE;
          end
        end
`endif

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (decoded from registered state)
  // -------------------------------------------------------------------------
  assign bs_ready = ready;
  assign done     = (state_reg == DONE);

`ifdef CCFF_READBACK_EN
  assign ccff_shift_en = load_shift || (state_reg == VERIFY);
  assign ccff_head     = (state_reg == VERIFY) ? ccff_tail : head_reg;
  assign busy          = (state_reg == LOAD) || (state_reg == VERIFY);
  assign error         = error_reg;
`else
  assign ccff_shift_en = load_shift;
  assign ccff_head     = head_reg;
  assign busy          = (state_reg == LOAD);
  assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_loader
//
// Drives two loaders that share a clock, a reset and the bitstream inputs:
//   inst 0: CHAIN_LEN=16, WORD_W=8
//   inst 1: CHAIN_LEN=12, WORD_W=8
// Each loader feeds a behavioural shift-register model of its chain. The
// expected head sequence is the concatenated words, MSB first, cut to the
// chain length. Expected chain contents and the error flag are derived
// directly from that sequence.
// ---------------------------------------------------------------------------
module tb_ccff_loader;

`ifdef CCFF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] start_i;
  logic [7:0] bs_data;
  logic       bs_valid;
  logic       flip_en;

  logic ready0, head0, sen0, busy0, done0, err0, tail0;
  logic ready1, head1, sen1, busy1, done1, err1, tail1;
  logic [1:0] ready_i, head_i, sen_i, busy_i, done_i, err_i;

  assign ready_i = {ready1, ready0};
  assign head_i  = {head1, head0};
  assign sen_i   = {sen1, sen0};
  assign busy_i  = {busy1, busy0};
  assign done_i  = {done1, done0};
  assign err_i   = {err1, err0};

  // Chain models. Bit 0 is nearest the head. The tail is bit LEN-1.
  logic [15:0] chain  [2];
  logic [15:0] rec    [2];   // first LEN head bits seen since start
  int          shift_cnt [2];
  int          stall_cnt [2];
  int          acc_cnt   [2];
  int          hold_viol [2];
  logic [1:0]  prev_head;
  logic [1:0]  prev_sen;
  logic [15:0] nxt_chain;

  int n_assert;
  int n_fail;

  assign tail0 = chain[0][15];
  assign tail1 = chain[1][11];

  ccff_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk(clk), .pReset(rst_n), .start(start_i[0]),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(ready0),
    .ccff_head(head0), .ccff_shift_en(sen0), .ccff_tail(tail0),
    .busy(busy0), .done(done0), .error(err0)
  );

  ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .prog_clk(clk), .pReset(rst_n), .start(start_i[1]),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(ready1),
    .ccff_head(head1), .ccff_shift_en(sen1), .ccff_tail(tail1),
    .busy(busy1), .done(done1), .error(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int len_of(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  // Chain models and run bookkeeping
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (start_i[k] && !busy_i[k]) begin
        shift_cnt[k] <= 0;
        stall_cnt[k] <= 0;
        acc_cnt[k]   <= 0;
        hold_viol[k] <= 0;
      end else begin
        if (bs_valid && ready_i[k]) acc_cnt[k] <= acc_cnt[k] + 1;
        if (sen_i[k]) begin
          nxt_chain = {chain[k][14:0], head_i[k]};
          // Optional corruption right after the final load bit lands.
          if (flip_en && shift_cnt[k] == len_of(k) - 1) nxt_chain[5] = ~nxt_chain[5];
          chain[k] <= nxt_chain;
          if (shift_cnt[k] < len_of(k)) rec[k] <= {rec[k][14:0], head_i[k]};
          shift_cnt[k] <= shift_cnt[k] + 1;
        end else if (busy_i[k] && shift_cnt[k] > 0 && shift_cnt[k] < len_of(k)) begin
          stall_cnt[k] <= stall_cnt[k] + 1;
        end
        if (busy_i[k] && !sen_i[k] && !prev_sen[k] && head_i[k] != prev_head[k])
          hold_viol[k] <= hold_viol[k] + 1;
      end
      prev_head[k] <= head_i[k];
      prev_sen[k]  <= sen_i[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input int k, input logic [7:0] w, input int gap);
    bit ok;
    ok = 1'b0;
    bs_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ready_i[k]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check($sformatf("ready_wait%0d", k), 32'(ok), 32'd1);
    repeat (gap) @(negedge clk);
    bs_valid = 1'b1;
    bs_data  = w;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ready_i[k]) begin ok = 1'b1; @(negedge clk); break; end
      @(negedge clk);
    end
    bs_valid = 1'b0;
    check($sformatf("accept%0d", k), 32'(ok), 32'd1);
  endtask

  task automatic run_load(input int k, input logic [7:0] w0, input logic [7:0] w1,
                          input int pre, input int gap, input bit restart);
    int          len;
    logic [15:0] mask, exp_bits, exp_chain;
    logic [15:0] both;
    bit          seen;
    len       = len_of(k);
    mask      = 16'((32'h1 << len) - 1);
    both      = {w0, w1};
    exp_bits  = both >> (16 - len);
    exp_chain = exp_bits ^ (flip_en ? 16'h0020 : 16'h0000);

    @(negedge clk);
    start_i[k] = 1'b1;
    @(negedge clk);
    start_i[k] = 1'b0;
    check($sformatf("busy_after_start%0d", k), 32'(busy_i[k]), 32'd1);
    repeat (pre) @(negedge clk);
    send_word(k, w0, 0);
    if (restart) begin
      start_i[k] = 1'b1;          // must be ignored while loading
      @(negedge clk);
      start_i[k] = 1'b0;
    end
    send_word(k, w1, gap);
    // Offer a further word; the loader must never take it.
    bs_valid = 1'b1;
    bs_data  = 8'hFF;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!seen && shift_cnt[k] == len) begin
        seen = 1'b1;
        check($sformatf("done_after_last%0d", k), 32'(done_i[k]), RB ? 32'd0 : 32'd1);
        check($sformatf("busy_after_last%0d", k), 32'(busy_i[k]), RB ? 32'd1 : 32'd0);
      end
      if (done_i[k]) break;
      @(negedge clk);
    end
    bs_valid = 1'b0;
    check($sformatf("last_bit_seen%0d", k), 32'(seen), 32'd1);
    check($sformatf("done%0d", k), 32'(done_i[k]), 32'd1);
    check($sformatf("busy_done%0d", k), 32'(busy_i[k]), 32'd0);
    check($sformatf("ready_done%0d", k), 32'(ready_i[k]), 32'd0);
    check($sformatf("shift_en_done%0d", k), 32'(sen_i[k]), 32'd0);
    check($sformatf("head_seq%0d", k), 32'(rec[k] & mask), 32'(exp_bits));
    check($sformatf("chain%0d", k), 32'(chain[k] & mask), 32'(exp_chain));
    check($sformatf("shifts%0d", k), 32'(shift_cnt[k]), 32'((RB ? 2 : 1) * len));
    check($sformatf("stalls%0d", k), 32'(stall_cnt[k]), 32'(gap));
    check($sformatf("accepted%0d", k), 32'(acc_cnt[k]), 32'd2);
    check($sformatf("head_hold%0d", k), 32'(hold_viol[k]), 32'd0);
    check($sformatf("error%0d", k), 32'(err_i[k]), 32'(RB && flip_en));
    $display("load inst=%0d words=%02h,%02h pre=%0d gap=%0d restart=%0d flip=%0d head=%04h chain=%04h err=%0d",
             k, w0, w1, pre, gap, restart, flip_en, rec[k] & mask, chain[k] & mask, err_i[k]);
  endtask

  initial begin
    logic [7:0] w0, w1;
    int k, pre, gap;
    bit ok, restart;
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start_i  = 2'b00;
    bs_valid = 1'b0;
    bs_data  = 8'h00;
    flip_en  = 1'b0;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("rst_ready%0d", j), 32'(ready_i[j]), 32'd0);
      check($sformatf("rst_head%0d", j),  32'(head_i[j]),  32'd0);
      check($sformatf("rst_sen%0d", j),   32'(sen_i[j]),   32'd0);
      check($sformatf("rst_busy%0d", j),  32'(busy_i[j]),  32'd0);
      check($sformatf("rst_done%0d", j),  32'(done_i[j]),  32'd0);
      check($sformatf("rst_error%0d", j), 32'(err_i[j]),   32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: back-to-back, 3-cycle gap, short chain, corrupted readback.
    run_load(0, 8'hA5, 8'h3C, 0, 0, 1'b0);
    run_load(0, 8'hA5, 8'h3C, 0, 3, 1'b0);
    run_load(1, 8'hA5, 8'h3C, 0, 0, 1'b0);
    flip_en = 1'b1;
    run_load(0, 8'hA5, 8'h3C, 0, 0, 1'b0);
    flip_en = 1'b0;
    run_load(0, 8'hA5, 8'h3C, 1, 0, 1'b1);

    // Reset in the middle of a load, after 7 bits have shifted.
    @(negedge clk);
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    bs_valid = 1'b1;
    bs_data  = 8'hA5;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (shift_cnt[0] == 7) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("reach_bit7", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready0), 32'd0);
    check("mid_rst_head",  32'(head0),  32'd0);
    check("mid_rst_sen",   32'(sen0),   32'd0);
    check("mid_rst_busy",  32'(busy0),  32'd0);
    check("mid_rst_done",  32'(done0),  32'd0);
    check("mid_rst_error", 32'(err0),   32'd0);
    bs_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy0), 32'd0);
    run_load(0, 8'hA5, 8'h3C, 0, 0, 1'b0);

    // Randomized loads on both chain lengths.
    for (int it = 0; it < 24; it++) begin
      k       = int'($urandom_range(0, 1));
      w0      = 8'($urandom);
      w1      = 8'($urandom);
      pre     = int'($urandom_range(0, 3));
      gap     = int'($urandom_range(0, 4));
      restart = 1'($urandom_range(0, 1));
      flip_en = ($urandom_range(0, 3) == 0);
      run_load(k, w0, w1, pre, gap, restart);
    end
    flip_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 64, meaning the number of configuration flip-flops in the target chain (≥1).
REQ-002 The block SHALL have parameter WORD_W, default 8, meaning the bitstream word width (≥1).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: prog_clk  input  1  programming clock, all state on rising edge.
REQ-004 The block SHALL have pReset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have start  input  1  single-cycle request to begin a load.
REQ-006 The block SHALL have bs_data  input  WORD_W  bitstream word, MSB shifted first.
REQ-007 The block SHALL have bs_valid  input  1  bs_data valid.
REQ-008 The block SHALL have bs_ready  output  1  word accepted when bs_valid && bs_ready.
REQ-009 The block SHALL have ccff_head  output  1  serial bit into the chain head.
REQ-010 The block SHALL have ccff_shift_en  output  1  chain advances on each prog_clk edge where it is high.
REQ-011 The block SHALL have ccff_tail  input  1  serial bit from the chain tail.
REQ-012 The block SHALL have busy  output  1, done  output  1  and error  output  1 as status outputs.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, VERIFY (macro only) and DONE.
REQ-014 IDLE or DONE + start SHALL go to LOAD; clear bit counter, done and error; start SHALL be ignored in LOAD/VERIFY.
REQ-015 In LOAD, bs_ready SHALL be high when the word shift register is empty or its last bit shifts this cycle, so full streaming gives one bit per cycle with no bubble.
REQ-016 An accepted word SHALL be emitted over the following WORD_W cycles, MSB first, with ccff_head = shift register MSB and ccff_shift_en = 1.
REQ-017 With the shift register empty and no word accepted, ccff_shift_en SHALL be 0 (stall) and ccff_head SHALL hold.
REQ-018 Exactly CHAIN_LEN bits SHALL be shifted.
REQ-019 If CHAIN_LEN is not a multiple of WORD_W, the unused trailing LSBs of the last word SHALL be discarded.
REQ-020 bs_ready SHALL go low in the cycle the CHAIN_LEN-th bit shifts.
REQ-021 After the CHAIN_LEN-th bit the FSM SHALL go to DONE (or VERIFY with macro).
REQ-022 In DONE: done=1 and busy=0, held until next start; ccff_shift_en=0; bs_ready=0.
REQ-023 busy SHALL be 1 exactly in LOAD and VERIFY.
REQ-024 ccff_tail SHALL be ignored outside VERIFY.

Reset
REQ-025 On pReset low, asynchronously: state=IDLE, counters and shift register cleared, bs_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, error=0.
REQ-026 Reset mid-LOAD or mid-VERIFY SHALL abort without completing the shift; chain contents are then undefined.

Configuration
REQ-027 Macro CCFF_READBACK_EN SHALL, when defined, add VERIFY and the CRC logic.
REQ-028 With CCFF_READBACK_EN, LOAD SHALL accumulate CRC-16 (poly 0x1021, init 0xFFFF, MSB-first) over the CHAIN_LEN bits shifted.
REQ-029 VERIFY SHALL run CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail (recirculation, contents preserved), accumulating a second CRC over ccff_tail.
REQ-030 On exit from VERIFY, error SHALL = (CRCs differ), then the FSM goes to DONE.
REQ-031 Without CCFF_READBACK_EN, no CRC or VERIFY logic SHALL exist; error SHALL be constant 0; LOAD SHALL go directly to DONE.

Verification
REQ-032 CHAIN_LEN=16, WORD_W=8, words 0xA5,0x3C back-to-back → ccff_head sequence 1010010100111100 with ccff_shift_en high 16 consecutive cycles; done=1 the next cycle; busy=0.
REQ-033 Same, bs_valid low 3 cycles between words → ccff_shift_en low exactly 3 cycles; chain model ends 0xA53C.
REQ-034 CHAIN_LEN=12, words 0xA5,0x3C → 12 shifts (101001010011); bs_ready never high for a third word; done=1.
REQ-035 Macro on, CHAIN_LEN=16, 16-bit chain model, load 0xA53C → 16 VERIFY cycles; error=0; model still 0xA53C. Flip model bit 5 before VERIFY → error=1.
REQ-036 pReset low at bit 7 of LOAD → all outputs at reset values immediately; start ignored mid-load; a new start after reset loads cleanly.
